// File: rtl/pw_code_sender_if.sv
// Handshake bundle between the control logic and the code sender.
// The control side drives start/abort/code; the sender returns the
// button lines and its progress flags.
interface pw_code_sender_if;
  logic       start;
  logic       abort;
  logic [7:0] code;
  logic [3:0] sym_out;
  logic [1:0] sym_idx;
  logic       busy;
  logic       done;

  // Control logic / loopback driver side.
  modport master (
    output start,
    output abort,
    output code,
    input  sym_out,
    input  sym_idx,
    input  busy,
    input  done
  );

  // Code sender side.
  modport slave (
    input  start,
    input  abort,
    input  code,
    output sym_out,
    output sym_idx,
    output busy,
    output done
  );
endinterface

// File: rtl/pw_code_sender.sv
// Four-button password code sender.
// Plays a latched 4-symbol code onto one-hot button lines {d,c,b,a}.
// Each symbol is held for HOLD_CYCLES clocks, then followed by an
// all-low gap of GAP_CYCLES clocks.  A one-cycle done pulse marks
// normal completion; abort returns to idle without a done pulse.
module pw_code_sender #(
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned GAP_CYCLES  = 50
) (
  input logic            clkin,
  input logic            reset,
  pw_code_sender_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX  = 2'd3;

  state_t      state;
  state_t      state_d;
  logic [15:0] cnt;
  logic [15:0] cnt_d;
  logic [1:0]  idx;
  logic [1:0]  idx_d;
  logic [7:0]  code_q;
  logic [7:0]  code_d;

  logic [3:0]  sym_out_q;
  logic [3:0]  sym_out_d;
  logic        busy_q;
  logic        busy_d;
  logic        done_q;
  logic        done_d;

  // Pick the 2-bit symbol at position sel out of a packed code.
  function automatic logic [1:0] pick_symbol(input logic [7:0] c,
                                             input logic [1:0] sel);
    logic [1:0] s;
    case (sel)
      2'd0:    s = c[1:0];
      2'd1:    s = c[3:2];
      2'd2:    s = c[5:4];
      default: s = c[7:6];
    endcase
    return s;
  endfunction

  // Symbol value to one-hot button line: 0=a, 1=b, 2=c, 3=d.
  function automatic logic [3:0] to_onehot(input logic [1:0] s);
    logic [3:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  // State, cycle counter, symbol index and latched code registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      code_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      code_q <= code_d;
    end
  end

  // Next-state logic: sequencing through HOLD/GAP per symbol.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    code_d  = code_q;

    case (state)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = HOLD;
          code_d  = bus.code;
        end
      end

      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt == GAP_LAST) begin
          cnt_d = '0;
          if (idx == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            state_d = HOLD;
            idx_d   = idx + 2'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end

      DONE: begin
        // Start is deliberately not sampled here; abort lands in the
        // same place, so it needs no separate branch.
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so outputs leave a register
  // on the same edge the state changes.
  always_comb begin
    sym_out_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_d)
      HOLD: begin
        sym_out_d = to_onehot(pick_symbol(code_d, idx_d));
        busy_d    = 1'b1;
      end
      GAP: begin
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        sym_out_d = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sym_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sym_out_q <= sym_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sym_out = sym_out_q;
  assign bus.sym_idx = idx;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_pw_code_sender.sv
// Bench for pw_code_sender with HOLD_CYCLES=3, GAP_CYCLES=2.
// A time-based model (offset since acceptance) predicts the outputs;
// directed scenarios add literal expectations on top.
module tb_pw_code_sender;

  localparam int H = 3;
  localparam int G = 2;
  localparam int P = H + G;
  localparam int RUN = 4 * P;

  logic clkin = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  pw_code_sender_if bus_if ();

  pw_code_sender #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running (t cycles since acceptance), 2 done cycle.
  int         m_mode = 0;
  int         m_t    = 0;
  logic [7:0] m_code = '0;

  always @(posedge clkin or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_t    = 0;
      m_code = '0;
    end else if (bus_if.abort) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (bus_if.start) begin
             m_mode = 1;
             m_t    = 0;
             m_code = bus_if.code;
           end
        1: begin
             m_t = m_t + 1;
             if (m_t == RUN) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle comparison of DUT against the model, plus invariants.
  always @(negedge clkin) begin
    logic [3:0] e_sym;
    logic [1:0] e_idx;
    logic       e_busy;
    logic       e_done;
    int         sidx;
    int         s;
    e_sym  = '0;
    e_idx  = '0;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (m_mode == 1) begin
      sidx   = m_t / P;
      s      = (int'(m_code) >> (2 * sidx)) & 3;
      e_idx  = 2'(sidx);
      e_busy = 1'b1;
      if ((m_t % P) < H) e_sym = 4'(1 << s);
    end else if (m_mode == 2) begin
      e_done = 1'b1;
    end
    check("model_sym_out", 32'(bus_if.sym_out), 32'(e_sym));
    check("model_busy", 32'(bus_if.busy), 32'(e_busy));
    check("model_done", 32'(bus_if.done), 32'(e_done));
    if (m_mode != 2) check("model_sym_idx", 32'(bus_if.sym_idx), 32'(e_idx));
    check("inv_onehot0", 32'($onehot0(bus_if.sym_out)), 32'd1);
    if (!bus_if.busy) check("inv_idle_quiet", 32'(bus_if.sym_out), 32'd0);
  end

  // Hand-computed output of one run of code 8'b11_10_01_00, edge 0..21.
  logic [3:0] lit_sym [22];
  logic [1:0] lit_idx [22];

  // Play one run from acceptance edge 0 to edge 21, pinning outputs to
  // the literal tables. rep: code 00 (all on line a). disturb: extra
  // start pulses at edges 4, 20, 21 and code changed to FF from edge 6.
  task automatic run_pinned(input logic [7:0] c, input bit rep, input bit disturb);
    logic [3:0] e_sym;
    bus_if.code  = c;
    bus_if.start = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clkin);
      bus_if.start = 1'b0;
      if (disturb && (k == 3 || k == 19 || k == 20)) bus_if.start = 1'b1;
      if (disturb && k == 5) bus_if.code = 8'hFF;
      e_sym = lit_sym[k];
      if (rep && e_sym != 4'd0) e_sym = 4'b0001;
      check("lit_sym_out", 32'(bus_if.sym_out), 32'(e_sym));
      check("lit_busy", 32'(bus_if.busy), (k < 20) ? 32'd1 : 32'd0);
      check("lit_done", 32'(bus_if.done), (k == 20) ? 32'd1 : 32'd0);
      if (k != 20) check("lit_sym_idx", 32'(bus_if.sym_idx), 32'(lit_idx[k]));
    end
  endtask

  initial begin
    lit_sym = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4,
                4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    lit_idx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.code  = 8'h00;
    #1 reset = 1'b0;
    repeat (2) @(negedge clkin);
    check("reset_sym_out", 32'(bus_if.sym_out), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_done", 32'(bus_if.done), 32'd0);
    check("reset_sym_idx", 32'(bus_if.sym_idx), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clkin);

    // Normal run, then a back-to-back run accepted in the first IDLE cycle.
    run_pinned(8'b11_10_01_00, 1'b0, 1'b0);
    run_pinned(8'b11_10_01_00, 1'b0, 1'b0);
    repeat (3) @(negedge clkin);

    // Repeated symbol: four separate pulses on line a.
    run_pinned(8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clkin);

    // Start and code changes during a run and in DONE are ignored.
    run_pinned(8'b11_10_01_00, 1'b0, 1'b1);
    @(negedge clkin);
    check("no_requeue_busy", 32'(bus_if.busy), 32'd0);
    repeat (2) @(negedge clkin);

    // Abort with start in IDLE: not accepted.
    bus_if.code  = 8'b11_10_01_00;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clkin);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    check("abort_idle_busy", 32'(bus_if.busy), 32'd0);
    check("abort_idle_sym", 32'(bus_if.sym_out), 32'd0);
    repeat (2) @(negedge clkin);

    // Abort during the second HOLD, then a fresh start at edge 9.
    bus_if.start = 1'b1;
    @(negedge clkin);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clkin);
    check("abort_pre_sym", 32'(bus_if.sym_out), 32'h2);
    bus_if.abort = 1'b1;
    @(negedge clkin);
    bus_if.abort = 1'b0;
    check("abort_sym_out", 32'(bus_if.sym_out), 32'd0);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_sym_idx", 32'(bus_if.sym_idx), 32'd0);
    @(negedge clkin);
    bus_if.start = 1'b1;
    @(negedge clkin);
    bus_if.start = 1'b0;
    check("restart_sym_out", 32'(bus_if.sym_out), 32'h1);
    check("restart_busy", 32'(bus_if.busy), 32'd1);
    repeat (19) @(negedge clkin);
    check("restart_last_busy", 32'(bus_if.busy), 32'd1);
    @(negedge clkin);
    check("restart_done", 32'(bus_if.done), 32'd1);
    check("restart_busy_fall", 32'(bus_if.busy), 32'd0);
    repeat (2) @(negedge clkin);

    // Asynchronous reset in the middle of the first GAP.
    bus_if.start = 1'b1;
    @(negedge clkin);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clkin);
    check("pre_reset_busy", 32'(bus_if.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 32'(bus_if.busy), 32'd0);
    check("async_sym_out", 32'(bus_if.sym_out), 32'd0);
    check("async_done", 32'(bus_if.done), 32'd0);
    @(negedge clkin);
    reset = 1'b1;
    repeat (8) @(negedge clkin);
    check("post_reset_busy", 32'(bus_if.busy), 32'd0);
    check("post_reset_sym", 32'(bus_if.sym_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
